// File: rtl/sf_pkg.sv
// Shared definitions for the smoothing-filter sequencer.
// Contents: default sizing parameters, FSM state encodings and the helper
// that sizes the running-sum register so it can never overflow.
package sf_pkg;

  localparam int unsigned SfM  = 5;   // window size
  localparam int unsigned SfDw = 8;   // sample width
  localparam int unsigned SfOw = 16;  // result width
  localparam int unsigned SfAw = 10;  // RAM address width
  localparam int unsigned SfLw = 11;  // length field width

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StErr  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Sum of M+1 DW-bit values (window plus the incoming sample before the
  // oldest is removed) fits in DW + clog2(M+1) bits.
  function automatic int unsigned sf_sum_w(int unsigned dw, int unsigned m);
    return dw + $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sf_window_buf.sv
// M-deep shift register holding the samples currently inside the window.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   clr_i         synchronous clear of all entries
//   push_i        shift data_i in at the newest end
//   data_i        incoming sample
//   oldest_o      sample pushed Depth pushes ago (zero until the buffer fills)
module sf_window_buf
  import sf_pkg::*;
#(
  parameter int unsigned Depth = SfM,
  parameter int unsigned Width = SfDw
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] oldest_o
);

  logic [Width-1:0] win_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) win_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < Depth; i++) win_q[i] <= '0;
    end else if (push_i) begin
      win_q[0] <= data_i;
      for (int i = 1; i < Depth; i++) win_q[i] <= win_q[i-1];
    end
  end

  assign oldest_o = win_q[Depth-1];

endmodule

// File: rtl/sf_sequencer.sv
// Moving-average sequencer: reads cfg_len samples from a synchronous-read
// sample RAM, keeps a running window sum and writes floor(sum/M) for every
// full window to a result RAM, one result per clock once the window fills.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   start_i, abort_i      run request (ignored while busy), sync abort
//   cfg_len_i             sample count, latched on an accepted start
//   busy_o, done_o        run in progress, end-of-run pulse
//   err_len_o             pulse with done_o when the latched length < M
//   rd_en_o, rd_addr_o    sample RAM read port, rd_data_i one cycle later
//   wr_en_o, wr_addr_o    result RAM write port
//   wr_data_o             window average, zero-extended
module sf_sequencer
  import sf_pkg::*;
#(
  parameter int unsigned M  = SfM,
  parameter int unsigned DW = SfDw,
  parameter int unsigned OW = SfOw,
  parameter int unsigned AW = SfAw,
  parameter int unsigned LW = SfLw
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [LW-1:0] cfg_len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_len_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [OW-1:0] wr_data_o
);

  localparam int unsigned SW = sf_sum_w(DW, M);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] rd_cnt_q, rd_cnt_d;   // reads issued
  logic [LW-1:0] in_cnt_q, in_cnt_d;   // samples received
  logic          rd_vld_q, rd_vld_d;   // rd_data_i carries a sample this cycle
  logic [SW-1:0] sum_q, sum_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [OW-1:0] wr_data_q, wr_data_d;

  logic          start_acc, run_active, kill, clr_win;
  logic [DW-1:0] oldest;
  logic [SW-1:0] sum_next, quot;

  assign start_acc  = (state_q == StIdle) && start_i && !abort_i;
  assign run_active = (state_q == StRun);
  assign kill       = abort_i && (state_q != StIdle);
  assign clr_win    = start_acc || kill;

  sf_window_buf #(
    .Depth (M),
    .Width (DW)
  ) u_win (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr_win),
    .push_i   (run_active && rd_vld_q),
    .data_i   (rd_data_i),
    .oldest_o (oldest)
  );

  // The buffer reads back zero until M samples are in, so the subtraction
  // needs no separate fill check. sum_q + x never exceeds (M+1) * max sample.
  assign sum_next = sum_q + SW'(rd_data_i) - SW'(oldest);
  assign quot     = sum_next / SW'(M);

  assign rd_en_o = run_active && (rd_cnt_q < len_q);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q;
    in_cnt_d  = in_cnt_q;
    rd_vld_d  = rd_en_o;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      StIdle: begin
        if (start_acc) begin
          len_d    = cfg_len_i;
          rd_cnt_d = '0;
          in_cnt_d = '0;
          sum_d    = '0;
          state_d  = (cfg_len_i < LW'(M)) ? StErr : StRun;
        end
      end
      StRun: begin
        if (rd_en_o) rd_cnt_d = rd_cnt_q + LW'(1);
        if (rd_vld_q) begin
          sum_d    = sum_next;
          in_cnt_d = in_cnt_q + LW'(1);
          if (in_cnt_q >= LW'(M - 1)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = AW'(in_cnt_q - LW'(M - 1));
            wr_data_d = OW'(quot);
          end
        end
        // All samples consumed; the last result is on the write port now.
        if (in_cnt_q == len_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    // Abort also drops a result sitting in the write stage.
    if (kill) begin
      state_d  = StIdle;
      rd_cnt_d = '0;
      in_cnt_d = '0;
      rd_vld_d = 1'b0;
      sum_d    = '0;
      wr_en_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      in_cnt_q  <= '0;
      rd_vld_q  <= 1'b0;
      sum_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      in_cnt_q  <= in_cnt_d;
      rd_vld_q  <= rd_vld_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy_o    = run_active;
  assign done_o    = (state_q == StDone) || (state_q == StErr);
  assign err_len_o = (state_q == StErr);
  assign rd_addr_o = AW'(rd_cnt_q);
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_sf_sequencer.sv
// Scoreboard bench for sf_sequencer: stimulus pushes expected writes and
// done pulses (with their cycle relative to the accepted start); a monitor
// pops and compares whenever the DUT strobes wr_en or done.
module tb_sf_sequencer;

  localparam int unsigned M  = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 16;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 11;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [LW-1:0] cfg_len;
  logic          busy, done, err_len, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0;
  logic [OW-1:0] wr_data;

  sf_sequencer #(
    .M  (M),
    .DW (DW),
    .OW (OW),
    .AW (AW),
    .LW (LW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .abort_i   (abort),
    .cfg_len_i (cfg_len),
    .busy_o    (busy),
    .done_o    (done),
    .err_len_o (err_len),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data)
  );

  always #5 clk = ~clk;

  // Sample RAM with a one-cycle synchronous read.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; bit err; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;
  int cur_len = 0;
  int rd_total = 0, busy_total = 0, rd_oob = 0, rd_bad = 0, last_addr = -1;

  // Monitor
  initial begin
    logic prev_rd;
    int   prev_addr, rel;
    wr_t  e;
    dn_t  d;
    prev_rd = 1'b0;
    prev_addr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rd = 1'b0;
      end else begin
        rel = cyc - start_cyc;
        if (busy) busy_total++;
        if (rd_en) begin
          rd_total++;
          if (int'(rd_addr) >= cur_len) rd_oob++;
          if (int'(rd_addr) != (prev_rd ? prev_addr + 1 : 0)) rd_bad++;
          last_addr = int'(rd_addr);
        end
        prev_rd = rd_en;
        prev_addr = int'(rd_addr);
        if (wr_en) begin
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=%0d cycle=%0d, none expected",
                     wr_addr, wr_data, rel);
          end else begin
            e = wr_q.pop_front();
            if (int'(wr_addr) != e.addr || int'(wr_data) != e.data || rel != e.cyc) begin
              errors++;
              $display("FAIL write: got addr=%0d data=%0d cycle=%0d, expected addr=%0d data=%0d cycle=%0d",
                       wr_addr, wr_data, rel, e.addr, e.data, e.cyc);
            end
          end
        end
        if (done || err_len) begin
          checks++;
          if (dn_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done=%0b err_len=%0b cycle=%0d", done, err_len, rel);
          end else begin
            d = dn_q.pop_front();
            if (!done || err_len != d.err || rel != d.cyc) begin
              errors++;
              $display("FAIL done: got done=%0b err_len=%0b cycle=%0d, expected done=1 err_len=%0b cycle=%0d",
                       done, err_len, rel, d.err, d.cyc);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_wr(input int c, input int a, input int dat);
    wr_t e;
    e.cyc = c; e.addr = a; e.data = dat;
    wr_q.push_back(e);
  endtask

  task automatic push_done(input int c, input bit er);
    dn_t d;
    d.cyc = c; d.err = er;
    dn_q.push_back(d);
  endtask

  // Returns at cycle 1 + 1ns of the new run.
  task automatic do_start(input int len);
    @(posedge clk); #1;
    cfg_len = LW'(len);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic full_run(input int len, input bit er, input int exp_reads, input int exp_last,
                          input int exp_busy, input int poke);
    int rd0, b0, oob0, bad0, n;
    cur_len = len;
    rd0 = rd_total; b0 = busy_total; oob0 = rd_oob; bad0 = rd_bad;
    push_done(er ? 1 : len + 3, er);
    do_start(len);
    if (poke > 0) begin
      repeat (poke - 1) @(posedge clk);
      #1;
      cfg_len = LW'(len + 10);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (dn_q.size() != 0 && n < len + 20) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", dn_q.size(), 0);
    dn_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("writes_left", wr_q.size(), 0);
    wr_q.delete();
    check("reads", rd_total - rd0, exp_reads);
    check("busy_cycles", busy_total - b0, exp_busy);
    check("rd_out_of_range", rd_oob - oob0, 0);
    check("rd_sequence", rd_bad - bad0, 0);
    if (exp_reads > 0) check("last_rd_addr", last_addr, exp_last);
  endtask

  task automatic fill_ramp10();
    for (int i = 0; i < 10; i++) mem[i] = DW'(10 * (i + 1));
  endtask

  task automatic fill_odd100();
    for (int i = 0; i < 100; i++) mem[i] = DW'(2 * i + 1);
  endtask

  task automatic expect_ramp10();
    for (int i = 0; i < 6; i++) push_wr(7 + i, i, 30 + 10 * i);
  endtask

  initial begin
    int rd0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_len = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #2;
    check("rst_strobes", int'({busy, done, err_len, rd_en, wr_en}), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Ramp 10..100, len 10
    fill_ramp10();
    expect_ramp10();
    full_run(10, 1'b0, 10, 9, 12, 0);

    // Saturated samples, len 1000
    for (int i = 0; i < 1000; i++) mem[i] = 8'd255;
    for (int i = 0; i < 996; i++) push_wr(7 + i, i, 255);
    full_run(1000, 1'b0, 1000, 999, 1002, 0);

    // Too short
    full_run(4, 1'b1, 0, 0, 0, 0);

    // len == M, truncating division: 16/5 = 3
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4; mem[4] = 8'd6;
    push_wr(7, 0, 3);
    full_run(5, 1'b0, 5, 4, 7, 0);

    // len == 2**AW, address must stop at all-ones
    for (int i = 0; i < 1024; i++) mem[i] = 8'd7;
    for (int i = 0; i < 1020; i++) push_wr(7 + i, i, 7);
    full_run(1024, 1'b0, 1024, 1023, 1026, 0);

    // Start during busy (len 20 offered at cycle 5) must not disturb the run
    fill_ramp10();
    expect_ramp10();
    full_run(10, 1'b0, 10, 9, 12, 5);

    // Abort together with start at cycle 20; average of 2i+1.. is 2i+5
    fill_odd100();
    for (int i = 0; i < 14; i++) push_wr(7 + i, i, 2 * i + 5);
    cur_len = 100;
    rd0 = rd_total;
    do_start(100);
    repeat (19) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b1; cfg_len = LW'(50);
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_strobes", int'({busy, done, err_len, rd_en, wr_en}), 0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_writes_left", wr_q.size(), 0);
    check("abort_reads", rd_total - rd0, 20);
    wr_q.delete();

    // Abort in idle is harmless; then golden rerun
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < 96; i++) push_wr(7 + i, i, 2 * i + 5);
    full_run(100, 1'b0, 100, 99, 102, 0);

    // Async reset in the middle of cycle 30
    for (int i = 0; i < 23; i++) push_wr(7 + i, i, 2 * i + 5);
    cur_len = 100;
    do_start(100);
    repeat (29) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_strobes", int'({busy, done, err_len, rd_en, wr_en}), 0);
    check("rst_mid_rd_addr", int'(rd_addr), 0);
    check("rst_mid_wr_addr", int'(wr_addr), 0);
    check("rst_mid_wr_data", int'(wr_data), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_writes_left", wr_q.size(), 0);
    wr_q.delete();

    // Power-up behaviour after reset
    fill_ramp10();
    expect_ramp10();
    full_run(10, 1'b0, 10, 9, 12, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
